// File: rtl/spi_master_cfg_if.sv
// Request/response and SPI pin bundle for spi_master_cfg.
// The master modport is the SPI master's view; slave is the controller/pin side.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic              ready;
  logic [DATA_W-1:0] tx_data;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic              miso;
  logic              sck;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    input  start, tx_data, cs_sel, cpol, cpha, lsb_first, miso,
    output ready, sck, mosi, cs_n, rx_data, rx_valid
  );

  modport slave (
    output start, tx_data, cs_sel, cpol, cpha, lsb_first, miso,
    input  ready, sck, mosi, cs_n, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer mode, bit order and chip select. Each transfer is
// framed as SETUP (CLK_DIV) -> XFER (2*DATA_W sck half-periods) -> HOLD (CLK_DIV).
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_cfg_if.master bus
);
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state;
  logic                ready_q;
  logic                sck_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_buf;
  logic                cpha_q;
  logic                lsb_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [IDX_W-1:0]    tx_idx;
  logic [IDX_W-1:0]    rx_idx;

  logic                tick;
  logic                last_chunk;
  logic                last_edge;
  logic [IDX_W-1:0]    tx_idx_nxt;
  logic [IDX_W-1:0]    rx_pos;
  logic                mosi_nxt;

  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx, input logic lsb);
    return lsb ? idx : (IDX_W'(DATA_W - 1) - idx);
  endfunction

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DATA_W - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Out-of-range selects leave every line deasserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == CS_W'(i)) cs[i] = 1'b0;
    return cs;
  endfunction

  // XFER is 2*DATA_W chunks of CLK_DIV cycles; the tick ending chunk i makes
  // sck edge i+2, and the final chunk ends the transfer without an edge.
  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_chunk = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
  assign last_edge  = (edge_cnt == EDGE_W'(2 * DATA_W - 2));
  assign tx_idx_nxt = inc_idx(tx_idx);
  assign mosi_nxt   = tx_q[bit_pos(tx_idx_nxt, lsb_q)];
  assign rx_pos     = bit_pos(rx_idx, lsb_q);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_q       <= '0;
      rx_buf     <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      tx_idx     <= '0;
      rx_idx     <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && ready_q) begin
            tx_q     <= bus.tx_data;
            cpha_q   <= bus.cpha;
            lsb_q    <= bus.lsb_first;
            cs_n_q   <= cs_decode(bus.cs_sel);
            sck_q    <= bus.cpol;
            mosi_q   <= bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_idx   <= '0;
            rx_idx   <= '0;
            rx_buf   <= '0;
            ready_q  <= 1'b0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (tick) begin
            // First leading edge: mode 0/2 samples, mode 1/3 keeps bit 0 on mosi.
            state <= XFER;
            sck_q <= ~sck_q;
            if (!cpha_q) begin
              rx_buf[rx_pos] <= bus.miso;
              rx_idx         <= inc_idx(rx_idx);
            end
          end
        end

        XFER: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (tick) begin
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (last_chunk) begin
              state <= HOLD;
            end else begin
              sck_q <= ~sck_q;
              if (edge_cnt[0] ^ cpha_q) begin
                rx_buf[rx_pos] <= bus.miso;
                rx_idx         <= inc_idx(rx_idx);
              end else if (cpha_q || !last_edge) begin
                tx_idx <= tx_idx_nxt;
                mosi_q <= mosi_nxt;
              end
            end
          end
        end

        HOLD: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (tick) begin
            state      <= IDLE;
            cs_n_q     <= '1;
            rx_data_q  <= rx_buf;
            rx_valid_q <= 1'b1;
            ready_q    <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: all four modes, both bit orders, chip-select
// decode, back-to-back transfers and mid-transfer reset, against a simple SPI slave.
module tb_spi_master_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  spi_master_cfg_if #(.DATA_W(8), .NUM_CS(4)) b();
  spi_master_cfg_if #(.DATA_W(8), .NUM_CS(3)) b3();

  spi_master_cfg #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .bus(b.master)
  );

  // A 2-bit select on three lines can carry an out-of-range index (3).
  spi_master_cfg #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: evaluated on negedge, reacts to sck edges the DUT made on the prior posedge.
  logic       loopback = 1'b1;
  logic [7:0] slv_tx   = 8'h00;
  logic       slv_cpol = 1'b0;
  logic       slv_cpha = 1'b0;
  logic       slv_lsb  = 1'b0;
  logic       slv_miso = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  logic       sck_prev = 1'b0;
  logic       cs_prev  = 1'b0;
  int         in_n     = 0;
  int         sh_n     = 0;
  int         edges    = 0;

  assign b.miso  = loopback ? b.mosi : slv_miso;
  assign b3.miso = b3.mosi;

  function automatic logic wbit(input logic [7:0] w, input int i, input logic lsb);
    int j;
    j = i % 8;
    return lsb ? w[j] : w[7-j];
  endfunction

  always @(negedge clk) begin
    logic cs_act;
    logic lead;
    cs_act = !(&b.cs_n);
    if (cs_act && !cs_prev) begin
      in_n = 0; sh_n = 0; edges = 0; mosi_cap = 8'h00;
      slv_miso = wbit(slv_tx, 0, slv_lsb);
    end else if (cs_act && (b.sck !== sck_prev)) begin
      edges++;
      lead = (sck_prev == slv_cpol);
      if (lead != slv_cpha) begin
        if (in_n < 8) mosi_cap[slv_lsb ? in_n : 7 - in_n] = b.mosi;
        in_n++;
      end else if (slv_cpha) begin
        slv_miso = wbit(slv_tx, sh_n, slv_lsb);
        sh_n++;
      end else begin
        sh_n++;
        slv_miso = wbit(slv_tx, sh_n, slv_lsb);
      end
    end
    sck_prev = b.sck;
    cs_prev  = cs_act;
  end

  task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [1:0] sel,
                          input logic pol, input logic pha, input logic lsb,
                          input logic [7:0] slave_word, input logic [7:0] exp_rx,
                          input logic [3:0] exp_cs, input bit pulse_mid);
    int lat;
    slv_cpol = pol; slv_cpha = pha; slv_lsb = lsb; slv_tx = slave_word;
    @(negedge clk);
    b.tx_data = tx; b.cs_sel = sel; b.cpol = pol; b.cpha = pha; b.lsb_first = lsb;
    b.start = 1'b1;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    b.tx_data = ~tx; b.cs_sel = ~sel; b.cpol = ~pol; b.cpha = ~pha; b.lsb_first = ~lsb;
    @(negedge clk);
    check({tag, "_setup_cs_n"}, 32'(b.cs_n), 32'(exp_cs));
    check({tag, "_setup_sck"}, 32'(b.sck), 32'(pol));
    check({tag, "_setup_ready"}, 32'(b.ready), 0);
    lat = 1;
    while (!b.rx_valid && lat < 100) begin
      b.start = pulse_mid && (lat == 20);
      @(negedge clk);
      lat++;
    end
    b.start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 37);
    check({tag, "_rx_data"}, 32'(b.rx_data), 32'(exp_rx));
    check({tag, "_mosi_word"}, 32'(mosi_cap), 32'(tx));
    check({tag, "_sck_edges"}, 32'(edges), 16);
    check({tag, "_done_cs_n"}, 32'(b.cs_n), 'hF);
    check({tag, "_done_ready"}, 32'(b.ready), 1);
    check({tag, "_idle_sck"}, 32'(b.sck), 32'(pol));
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(b.rx_valid), 0);
    check({tag, "_no_requeue"}, 32'(b.ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int hits;
    b.start = 1'b0; b.tx_data = 8'h00; b.cs_sel = 2'd0;
    b.cpol = 1'b0; b.cpha = 1'b0; b.lsb_first = 1'b0;
    b3.start = 1'b0; b3.tx_data = 8'h00; b3.cs_sel = 2'd0;
    b3.cpol = 1'b0; b3.cpha = 1'b0; b3.lsb_first = 1'b0;

    // Reset with start held high: start must be ignored.
    rst = 1'b1;
    b.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(b.ready), 1);
    check("rst_sck", 32'(b.sck), 0);
    check("rst_mosi", 32'(b.mosi), 0);
    check("rst_cs_n", 32'(b.cs_n), 'hF);
    check("rst_rx_valid", 32'(b.rx_valid), 0);
    check("rst_rx_data", 32'(b.rx_data), 0);
    b.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(b.cs_n), 'hF);

    // Mode 0 MSB first, loopback: mosi 1,0,1,0,0,1,0,1.
    loopback = 1'b1;
    run_xfer("m0", 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 4'hE, 1'b0);

    // Mode 2 (sample on leading/falling edge).
    loopback = 1'b0;
    run_xfer("m2", 8'hC3, 2'd1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 4'hD, 1'b0);

    // Mode 3 LSB first; sck idles high from the mode 2 transfer.
    check("m3_sck_before", 32'(b.sck), 1);
    run_xfer("m3", 8'h3C, 2'd0, 1'b1, 1'b1, 1'b1, 8'h96, 8'h96, 4'hE, 1'b0);

    // Mode 1 (sample on trailing/falling edge).
    run_xfer("m1", 8'h81, 2'd3, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, 4'h7, 1'b0);

    // cs_sel=2, LSB first, with a start pulse mid-transfer that must be ignored.
    run_xfer("cs2", 8'h4E, 2'd2, 1'b0, 1'b0, 1'b1, 8'hB1, 8'hB1, 4'hB, 1'b1);

    // start held continuously: back-to-back with a one-cycle cs_n gap.
    loopback = 1'b1;
    slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0;
    @(negedge clk);
    b.tx_data = 8'h12; b.cs_sel = 2'd1; b.cpol = 1'b0; b.cpha = 1'b0; b.lsb_first = 1'b0;
    b.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    lat = 1;
    while (!b.rx_valid && lat < 100) begin
      if (lat == 10) b.tx_data = 8'hE7;
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 37);
    check("b2b_first_rx", 32'(b.rx_data), 'h12);
    check("b2b_gap_cs_n", 32'(b.cs_n), 'hF);
    @(posedge clk);
    #1;
    b.start = 1'b0;
    @(negedge clk);
    check("b2b_second_ready", 32'(b.ready), 0);
    check("b2b_second_cs_n", 32'(b.cs_n), 'hD);
    lat = 1;
    while (!b.rx_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 32'(lat), 37);
    check("b2b_second_rx", 32'(b.rx_data), 'hE7);

    // Reset after the 3rd sck edge aborts the transfer without rx_valid.
    @(negedge clk);
    b.tx_data = 8'h77; b.cs_sel = 2'd0; b.cpol = 1'b0; b.cpha = 1'b0; b.lsb_first = 1'b0;
    b.start = 1'b1;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    lat = 0;
    @(negedge clk);
    #1;
    while (edges < 3 && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("rst_mid_edges", 32'(edges), 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cs_n", 32'(b.cs_n), 'hF);
    check("rst_mid_sck", 32'(b.sck), 0);
    check("rst_mid_ready", 32'(b.ready), 1);
    check("rst_mid_rx_data", 32'(b.rx_data), 0);
    check("rst_mid_mosi", 32'(b.mosi), 0);
    rst = 1'b0;
    hits = 0;
    repeat (60) begin
      @(negedge clk);
      if (b.rx_valid) hits++;
    end
    check("rst_mid_no_valid", 32'(hits), 0);
    check("rst_mid_idle_ready", 32'(b.ready), 1);

    // Out-of-range select: transfer completes, no cs_n line ever asserts.
    @(negedge clk);
    b3.tx_data = 8'h6B; b3.cs_sel = 2'd3; b3.cpol = 1'b0; b3.cpha = 1'b0; b3.lsb_first = 1'b0;
    b3.start = 1'b1;
    @(posedge clk);
    #1;
    b3.start = 1'b0;
    @(negedge clk);
    check("oor_busy", 32'(b3.ready), 0);
    lat = 1;
    hits = 0;
    while (!b3.rx_valid && lat < 100) begin
      if (b3.cs_n != 3'b111) hits++;
      @(negedge clk);
      lat++;
    end
    check("oor_latency", 32'(lat), 37);
    check("oor_cs_low_cycles", 32'(hits), 0);
    check("oor_rx_data", 32'(b3.rx_data), 'h6B);
    check("oor_cs_n", 32'(b3.cs_n), 'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
